// File: rtl/escalonador_de_padroes_pkg.sv
// Shared types and default sizes for the pattern-list scheduler.
// Holds the FSM state enum and the default width/size constants.
package escalonador_pkg;

    localparam int DEF_N_SLOTS  = 8;
    localparam int DEF_CMD_W    = 4;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_LIST_LEN = 203;
    localparam int DEF_SCORE_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        LOAD,
        DONE
    } estado_t;

endpackage

// File: rtl/escalonador_de_padroes_arbitro_rr.sv
// Combinational round-robin arbiter: rotate, priority-pick, rotate back.
// Ports: req[N] requests, last_grant index; grant index, valid when any req.
module arbitro_rr #(
    parameter int N = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [IDX_W-1:0] start;
    logic [N-1:0]     rot;

    always_comb begin
        start = (last_grant == IDX_W'(N - 1)) ? '0 : last_grant + 1'b1;
        // rot[j] = req[(j + start) mod N]
        rot   = (req >> start) | (req << (N - int'(start)));
        grant = '0;
        valid = 1'b0;
        // Descending scan so the lowest rotated position wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant = IDX_W'((int'(start) + k) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/escalonador_de_padroes.sv
// Round-robin sequencer sharing the pattern-list ROM among lane instances.
// Ports: CLOCK_25/reset; trocar_req, ponto_in in; list_addr/list_data ROM;
// cmd_out/cmd_load to lanes; pending, score, fim_de_jogo status.
module escalonador_de_padroes
    import escalonador_pkg::*;
#(
    parameter int N_SLOTS  = DEF_N_SLOTS,
    parameter int CMD_W    = DEF_CMD_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LIST_LEN = DEF_LIST_LEN,
    parameter int SCORE_W  = DEF_SCORE_W
) (
    input  logic               CLOCK_25,
    input  logic               reset,
    input  logic [N_SLOTS-1:0] trocar_req,
    input  logic [N_SLOTS-1:0] ponto_in,
    output logic [ADDR_W-1:0]  list_addr,
    input  logic [CMD_W-1:0]   list_data,
    output logic [CMD_W-1:0]   cmd_out,
    output logic [N_SLOTS-1:0] cmd_load,
    output logic [N_SLOTS-1:0] pending,
    output logic [SCORE_W-1:0] score,
    output logic               fim_de_jogo
);

    localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int PC_W  = $clog2(N_SLOTS + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LIST_LEN - 1);

    if (LIST_LEN > (1 << ADDR_W)) begin : g_len_chk
        $error("LIST_LEN does not fit in ADDR_W");
    end

    estado_t          state;
    estado_t          state_nx;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] arb_grant;
    logic             arb_valid;
    logic [ADDR_W-1:0] ptr;
    logic [N_SLOTS-1:0] grant_oh;
    logic [PC_W-1:0]  pc;
    logic [SCORE_W:0] sum;

    arbitro_rr #(.N(N_SLOTS)) u_arb (
        .req        (pending),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign grant_oh  = N_SLOTS'(1) << grant_q;
    assign list_addr = ptr;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (arb_valid) state_nx = WAIT;
            WAIT:    state_nx = LOAD;
            LOAD:    state_nx = (ptr == LAST_ADDR) ? DONE : IDLE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            ptr         <= '0;
            pending     <= '0;
            last_grant  <= IDX_W'(N_SLOTS - 1);
            grant_q     <= '0;
            cmd_out     <= '0;
            cmd_load    <= '0;
            fim_de_jogo <= 1'b0;
        end else begin
            cmd_load <= '0;
            if (state == IDLE && arb_valid) grant_q <= arb_grant;
            if (state == LOAD) begin
                cmd_out    <= list_data;
                cmd_load   <= grant_oh;
                // A fresh request on the granted slot survives the clear.
                pending    <= (pending & ~grant_oh) | trocar_req;
                last_grant <= grant_q;
                if (ptr == LAST_ADDR) fim_de_jogo <= 1'b1;
                else                  ptr <= ptr + 1'b1;
            end else begin
                pending <= pending | trocar_req;
            end
        end
    end

    always_comb begin
        pc = '0;
        for (int i = 0; i < N_SLOTS; i++) pc = pc + PC_W'(ponto_in[i]);
        sum = {1'b0, score} + (SCORE_W + 1)'(pc);
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset)             score <= '0;
        else if (!fim_de_jogo) score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end

endmodule

// File: doc/escalonador_de_padroes.md
Name: escalonador_de_padroes

Overview:
Sequences the shared pattern-list ROM among the N lane "pattern" instances. Each lane raises a one-cycle trocar pulse when it needs its next command. The block latches these requests and serves them round-robin, one ROM read per grant, and delivers the fetched command with a one-hot per-lane load strobe. It also replaces the OR'd ponto edge counter with a synchronous saturating score counter and asserts fim_de_jogo when the list is exhausted.

Parameters:
N_SLOTS, 8, number of lane pattern instances
CMD_W, 4, command width (one bit per lane column)
ADDR_W, 8, pattern-list address width
LIST_LEN, 203, number of valid list entries (addresses 0..LIST_LEN-1)
SCORE_W, 8, score width

Ports:
CLOCK_25  in  1  system clock (25 MHz pixel clock domain)
reset  in  1  synchronous, active-high reset
trocar_req  in  N_SLOTS  per-lane next-command request pulses
ponto_in  in  N_SLOTS  per-lane point pulses, one cycle each
list_addr  out  ADDR_W  pattern-list ROM address (registered, equals read pointer)
list_data  in  CMD_W  ROM data, valid one cycle after list_addr changes
cmd_out  out  CMD_W  command delivered to the granted lane (registered)
cmd_load  out  N_SLOTS  one-hot, one-cycle load strobe qualifying cmd_out
pending  out  N_SLOTS  latched unserved requests (debug/status)
score  out  SCORE_W  saturating score
fim_de_jogo  out  1  list exhausted; sticky until reset

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and takes priority on any edge. After reset: state IDLE, ptr=0 (list_addr=0), pending=0, last_grant=N_SLOTS-1 (slot 0 has first priority), cmd_out=0, cmd_load=0, score=0, fim_de_jogo=0. Reset mid-operation discards the in-flight grant; no cmd_load follows.
- Request latch: pending[i] <= pending[i] | trocar_req[i] every cycle, including in DONE.
  - Clearing happens only in LOAD, for the granted bit.
  - A trocar_req on the granted bit in the LOAD cycle wins: the bit stays set and the request is served again later.
- FSM:
  - IDLE: if pending!=0, grant = first set bit searching from last_grant+1 with wrap; -> WAIT. Otherwise stay in IDLE.
  - WAIT: one cycle so list_data settles for list_addr=ptr; -> LOAD.
  - LOAD: cmd_out<=list_data; cmd_load<=onehot(grant); pending[grant] cleared; last_grant<=grant. Then:
    - if ptr==LIST_LEN-1: fim_de_jogo<=1 and go to DONE (ptr holds);
    - else ptr<=ptr+1 and go to IDLE.
  - DONE: absorbing until reset; cmd_load stays 0.
- cmd_load is high for exactly one cycle per grant; otherwise 0. cmd_out holds its last value between loads.
- Latency: trocar_req sampled at edge E, FSM in IDLE → cmd_load high in the cycle after edge E+3. Maximum throughput is one grant per 3 cycles. Fairness: each waiting lane is served within N_SLOTS grants.
- Score: score <= min(score + popcount(ponto_in), 2^SCORE_W-1) every cycle. Multiple lanes in one cycle all count. Score is frozen once fim_de_jogo=1.
- Widths: the popcount is $clog2(N_SLOTS+1) bits wide. Compute the sum in SCORE_W+1 bits, then saturate. LIST_LEN must be ≤ 2^ADDR_W (elaboration check).

Decomposition:
- Package escalonador_pkg: FSM state enum (IDLE, WAIT, LOAD, DONE); default constants N_SLOTS, CMD_W, ADDR_W, SCORE_W.
- Sub-module arbitro_rr (parameter N): inputs req[N] and last_grant index; outputs grant index and valid. Purely combinational rotate-priority-rotate.
- The parent holds the FSM, pending register, ptr, and score.

Test Plan:
- Reset: assert reset 2 cycles → list_addr=0, cmd_load=0, cmd_out=0, score=0, fim_de_jogo=0, pending=0.
- Single request: list[0]=4'h5; trocar_req=8'b00001000 for 1 cycle → cmd_load=8'b00001000 and cmd_out=4'h5 exactly 3 edges later, one cycle wide; list_addr=1 afterwards; pending=0.
- Simultaneous requests: trocar_req=8'b10000101 once, list[0..2]=1,2,3 → loads to slots 0,2,7 in that order, 3 cycles apart, cmd_out 1,2,3; ptr=3.
- Fairness and re-request race: slot 0 pulses every cycle and slot 5 pulses once → grant order 0,5,0,0…. A slot-0 request in its own LOAD cycle keeps pending[0]=1.
- Score: ponto_in=8'b10100001 for 1 cycle → score +3. Preload score=254, then ponto_in with 3 bits set → score=255 and stays 255.
- End of list and mid-operation reset, with LIST_LEN=4:
  - 4 grants → fim_de_jogo=1 after the 4th load; further requests set pending but give no cmd_load; ponto_in leaves score unchanged.
  - Reset asserted in WAIT → no cmd_load, all outputs back to reset values.
